bus_datapath_engine: RTL and testbench
======================================

# bus_datapath_engine

Parametrised successor to the phase-1 bus datapath. It holds a register file with NREGS entries, plus the HI, LO, Y, Z (ZHigh/ZLow), InPort and OutPort registers. A built-in micro-step controller executes one register-to-register ALU command per handshake, so the control unit no longer drives individual Rin/Rout strobes. Multiply and divide are multi-cycle: shift-add and restoring algorithms respectively, both signed.

## Interface
Parameters:
- DATA_W, 32, register and bus width (≥8).
- NREGS, 16, register-file depth (power of two, ≥4).
- IMM_W, 19, immediate field width, sign-extended to DATA_W.
- ZERO_R0, 1: when 1, R0 reads as 0 and writes to it are discarded; when 0, R0 is an ordinary register.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  5  operation code (see Operation).
- cmd_ra  in  log2(NREGS)  destination register.
- cmd_rb  in  log2(NREGS)  first source register.
- cmd_rc  in  log2(NREGS)  second source register.
- cmd_imm  in  IMM_W  immediate.
- in_data  in  DATA_W  input port data, sampled by IN.
- out_port  out  DATA_W  OutPort register.
- done  out  1  one-cycle pulse: command retired.
- err  out  1  one-cycle pulse, concurrent with done: illegal opcode.
- div0  out  1  one-cycle pulse, concurrent with done: DIV with zero divisor.
- dbg_addr  in  log2(NREGS)  debug read select.
- dbg_data  out  DATA_W  combinational read of R[dbg_addr]; obeys ZERO_R0.
- dbg_hi, dbg_lo  out  DATA_W each  current HI and LO.

## Operation
- Opcodes 0–8 use register operands, with Y=R[rb] and B=R[rc]:
  - 0 ADD, 1 SUB, 2 AND, 3 OR.
  - 4 SHR, 5 SHRA, 6 SHL, 7 ROR, 8 ROL: shift amount is B[log2(DATA_W)-1:0].
- Opcodes 9–11 use Y=R[rb] and B=sext(imm): 9 ADDI, 10 ANDI, 11 ORI.
- 12 MUL: {HI,LO} = signed Y×B.
- 13 DIV: LO = quotient truncated toward zero; HI = remainder, taking the sign of the dividend.
- 14 NEG: R[ra] = −R[rb].
- 15 NOT: R[ra] = ~R[rb].
- 16 MFHI: R[ra] = HI.
- 17 MFLO: R[ra] = LO.
- 18 IN: R[ra] = in_data, sampled on the write-back edge.
- 19 OUT: out_port = R[rb].
- 20–31 are illegal: no register changes; err and done pulse.
- Arithmetic wraps modulo 2^DATA_W. No carry or overflow flags.
- DIV by zero: LO = all-ones, HI = dividend, div0 pulses. No iterations are spent; the FSM proceeds straight to WB_LO.
- FSM states:
  - IDLE: on cmd_valid, latch the command and go to LOADY.
  - LOADY: Y ← R[rb]; go to EXEC.
  - EXEC:
    - Single-cycle ops: Z ← alu(Y, B); go to WB.
    - MUL/DIV: iterate DATA_W cycles in EXEC, then go to WB_LO.
  - WB: R[ra] ← ZLow (or out_port for OUT); done; go to IDLE.
  - WB_LO: LO ← ZLow; go to WB_HI.
  - WB_HI: HI ← ZHigh; done; go to IDLE.
- Illegal ops pass through LOADY/EXEC/WB with all writes suppressed.
- Sources are read before the destination is written, so ra = rb = rc is legal.
- Reset values: all registers, HI, LO, Y, Z and out_port are 0. State is IDLE, so cmd_ready=1 and done/err/div0=0.

## Timing
- Handshake: a command is accepted on the rising edge where cmd_valid && cmd_ready. Command fields are captured on that edge and may change afterward.
- Single-cycle ops: done is high in the cycle after the 4th edge counted from the accept edge (accept = edge 1). The result is visible on dbg_data in that same cycle, and cmd_ready is also high in that cycle. This allows back-to-back commands every 4 cycles.
- MUL/DIV: done follows edge DATA_W+4, i.e. 36 edges for DATA_W=32.
- DIV by zero: done follows edge 5.
- cmd_valid while busy is ignored. No command queueing.
- done, err and div0 are registered and last exactly one cycle.
- Reset mid-command: the operation is abandoned immediately (asynchronously). Nothing from the operation is written. cmd_ready is high in the first cycle after reset deasserts.

## Test plan
- Reset, then preload R1=5 and R2=7 via IN ops. Issue ADD ra=3, rb=1, rc=2 → R3=12; done pulses 4 cycles after accept; cmd_ready is low for 3 cycles.
- R1=−3 (0xFFFFFFFD), R2=7, MUL → HI=0xFFFFFFFF, LO=0xFFFFFFEB; done after 36 cycles; then MFLO ra=4 → R4=0xFFFFFFEB.
- R1=−7, R2=2, DIV → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV with R2=0 → LO=0xFFFFFFFF, HI=0xFFFFFFF9, div0 and done both pulse after 5 cycles.
- With ZERO_R0=1, ADDI ra=0, rb=1, imm=0x7FFFF → R0 reads 0. Then ADDI ra=5, rb=0, imm=0x40000 → R5=0xFFFC0000 (sign extension).
- Shift tests with R1=0x80000001 and R2=33:
  - SHRA → 0xC0000000 (only the low 5 bits of R2 are used).
  - ROL → 0x00000003.
  - SHL → 0x00000002.
- Assert reset at EXEC iteration 10 of a MUL → HI, LO and all registers stay 0; no done pulse; cmd_ready=1 after release. Illegal opcode 25 → err and done pulse, and no register changes.

Source files
------------

// File: rtl/bus_datapath_engine_if.sv
// Command/bus bundle for bus_datapath_engine: command handshake, I/O ports,
// completion pulses and debug read-back, with master/slave views.
interface bus_datapath_engine_if #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int IMM_W  = 19
);
  localparam int AW = $clog2(NREGS);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [4:0]        cmd_op;
  logic [AW-1:0]     cmd_ra;
  logic [AW-1:0]     cmd_rb;
  logic [AW-1:0]     cmd_rc;
  logic [IMM_W-1:0]  cmd_imm;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] out_port;
  logic              done;
  logic              err;
  logic              div0;
  logic [AW-1:0]     dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [DATA_W-1:0] dbg_hi;
  logic [DATA_W-1:0] dbg_lo;

  modport slave (
    input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rc, cmd_imm, in_data, dbg_addr,
    output cmd_ready, out_port, done, err, div0, dbg_data, dbg_hi, dbg_lo
  );

  modport master (
    output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_rc, cmd_imm, in_data, dbg_addr,
    input  cmd_ready, out_port, done, err, div0, dbg_data, dbg_hi, dbg_lo
  );
endinterface

// File: rtl/bus_datapath_engine.sv
// Register file plus HI/LO/Y/Z datapath sequenced by a micro-step controller:
// one ALU command per handshake, multi-cycle signed Booth MUL and restoring DIV.
module bus_datapath_engine #(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 16,
  parameter int IMM_W   = 19,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  bus_datapath_engine_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int SW = $clog2(DATA_W);
  localparam logic [SW-1:0] LAST_ITER = SW'(DATA_W - 1);

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3;
  localparam logic [4:0] OP_SHR  = 5'd4,  OP_SHRA = 5'd5,  OP_SHL  = 5'd6,  OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8,  OP_ADDI = 5'd9,  OP_ANDI = 5'd10, OP_ORI  = 5'd11;
  localparam logic [4:0] OP_MUL  = 5'd12, OP_DIV  = 5'd13, OP_NEG  = 5'd14, OP_NOT  = 5'd15;
  localparam logic [4:0] OP_MFHI = 5'd16, OP_MFLO = 5'd17, OP_IN   = 5'd18, OP_OUT  = 5'd19;

  typedef enum logic [2:0] {S_IDLE, S_LOADY, S_EXEC, S_WB, S_WB_LO, S_WB_HI} state_t;

  state_t            state_q, state_d;
  logic [4:0]        op_q;
  logic [AW-1:0]     ra_q, rb_q, rc_q;
  logic [IMM_W-1:0]  imm_q;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] y_q, zHigh_q, zLow_q, hi_q, lo_q, outPort_q;
  logic              zExt_q, qm1_q;
  logic [SW-1:0]     iter_q;
  logic              done_q, err_q, div0_q;

  logic              cmdReady, doneD, errD, div0D;
  logic [DATA_W-1:0] regY, regB, immExt, opB, aluOut;
  logic [SW-1:0]     shamt;
  logic              isImm, isIllegal, divZero, wrAllowed;
  logic [DATA_W:0]   mulAcc, mulM, mulSum;
  logic [DATA_W-1:0] divMag, dividendMag, remShift, remNext, quoNext, quoFinal, remFinal;
  logic              divGeq;

  // Operand fetch; R0 reads as zero when hardwired.
  assign regY      = (ZERO_R0 && rb_q == '0) ? '0 : regs_q[rb_q];
  assign regB      = (ZERO_R0 && rc_q == '0) ? '0 : regs_q[rc_q];
  assign immExt    = DATA_W'($signed(imm_q));
  assign isImm     = (op_q == OP_ADDI) || (op_q == OP_ANDI) || (op_q == OP_ORI);
  assign opB       = isImm ? immExt : regB;
  assign shamt     = opB[SW-1:0];
  assign isIllegal = (op_q > OP_OUT);
  assign divZero   = (regB == '0);
  assign wrAllowed = !(ZERO_R0 && ra_q == '0);

  always_comb begin
    aluOut = '0;
    case (op_q)
      OP_ADD, OP_ADDI: aluOut = y_q + opB;
      OP_SUB:          aluOut = y_q - opB;
      OP_AND, OP_ANDI: aluOut = y_q & opB;
      OP_OR,  OP_ORI:  aluOut = y_q | opB;
      OP_SHR:          aluOut = y_q >> shamt;
      OP_SHRA:         aluOut = $unsigned($signed(y_q) >>> shamt);
      OP_SHL:          aluOut = y_q << shamt;
      OP_ROR:          aluOut = (y_q >> shamt) | (y_q << (DATA_W - int'(shamt)));
      OP_ROL:          aluOut = (y_q << shamt) | (y_q >> (DATA_W - int'(shamt)));
      OP_NEG:          aluOut = -y_q;
      OP_NOT:          aluOut = ~y_q;
      OP_MFHI:         aluOut = hi_q;
      OP_MFLO:         aluOut = lo_q;
      OP_OUT:          aluOut = y_q;
      default:         aluOut = '0;
    endcase
  end

  // Radix-2 Booth step; the extra accumulator bit absorbs the most-negative multiplicand.
  always_comb begin
    mulAcc = {zExt_q, zHigh_q};
    mulM   = {y_q[DATA_W-1], y_q};
    case ({zLow_q[0], qm1_q})
      2'b01:   mulSum = mulAcc + mulM;
      2'b10:   mulSum = mulAcc - mulM;
      default: mulSum = mulAcc;
    endcase
  end

  // Restoring division on magnitudes, signs restored on the final iteration.
  assign divMag      = regB[DATA_W-1] ? -regB : regB;
  assign dividendMag = regY[DATA_W-1] ? -regY : regY;
  assign remShift    = {zHigh_q[DATA_W-2:0], zLow_q[DATA_W-1]};
  assign divGeq      = (remShift >= divMag);
  assign remNext     = divGeq ? (remShift - divMag) : remShift;
  assign quoNext     = {zLow_q[DATA_W-2:0], divGeq};
  assign quoFinal    = (y_q[DATA_W-1] ^ regB[DATA_W-1]) ? -quoNext : quoNext;
  assign remFinal    = y_q[DATA_W-1] ? -remNext : remNext;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cmdReady = 1'b0;
    doneD    = 1'b0;
    errD     = 1'b0;
    div0D    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmdReady = 1'b1;
        if (bus.cmd_valid) state_d = S_LOADY;
      end
      S_LOADY: state_d = S_EXEC;
      S_EXEC: begin
        if (op_q == OP_MUL) begin
          if (iter_q == LAST_ITER) state_d = S_WB_LO;
        end else if (op_q == OP_DIV) begin
          if (divZero || iter_q == LAST_ITER) state_d = S_WB_LO;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
        doneD   = 1'b1;
        errD    = isIllegal;
      end
      S_WB_LO: state_d = S_WB_HI;
      S_WB_HI: begin
        state_d = S_IDLE;
        doneD   = 1'b1;
        div0D   = (op_q == OP_DIV) && divZero;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      op_q <= '0; ra_q <= '0; rb_q <= '0; rc_q <= '0; imm_q <= '0;
      y_q <= '0; zHigh_q <= '0; zLow_q <= '0; zExt_q <= 1'b0; qm1_q <= 1'b0;
      hi_q <= '0; lo_q <= '0; outPort_q <= '0; iter_q <= '0;
      done_q <= 1'b0; err_q <= 1'b0; div0_q <= 1'b0;
    end else begin
      done_q <= doneD;
      err_q  <= errD;
      div0_q <= div0D;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op_q  <= bus.cmd_op;
            ra_q  <= bus.cmd_ra;
            rb_q  <= bus.cmd_rb;
            rc_q  <= bus.cmd_rc;
            imm_q <= bus.cmd_imm;
          end
        end
        S_LOADY: begin
          y_q    <= regY;
          iter_q <= '0;
          zExt_q <= 1'b0;
          qm1_q  <= 1'b0;
          if (op_q == OP_MUL) begin
            zHigh_q <= '0;
            zLow_q  <= regB;
          end else if (op_q == OP_DIV) begin
            zHigh_q <= '0;
            zLow_q  <= dividendMag;
          end
        end
        S_EXEC: begin
          if (op_q == OP_MUL) begin
            zExt_q  <= mulSum[DATA_W];
            zHigh_q <= mulSum[DATA_W:1];
            zLow_q  <= {mulSum[0], zLow_q[DATA_W-1:1]};
            qm1_q   <= zLow_q[0];
            iter_q  <= iter_q + SW'(1);
          end else if (op_q == OP_DIV) begin
            if (divZero) begin
              zHigh_q <= y_q;
              zLow_q  <= '1;
            end else if (iter_q == LAST_ITER) begin
              zHigh_q <= remFinal;
              zLow_q  <= quoFinal;
            end else begin
              zHigh_q <= remNext;
              zLow_q  <= quoNext;
              iter_q  <= iter_q + SW'(1);
            end
          end else begin
            zLow_q <= aluOut;
          end
        end
        S_WB: begin
          if (!isIllegal) begin
            if (op_q == OP_OUT)  outPort_q      <= zLow_q;
            else if (wrAllowed)  regs_q[ra_q]   <= (op_q == OP_IN) ? bus.in_data : zLow_q;
          end
        end
        S_WB_LO: lo_q <= zLow_q;
        S_WB_HI: hi_q <= zHigh_q;
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready = cmdReady;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.div0      = div0_q;
  assign bus.out_port  = outPort_q;
  assign bus.dbg_hi    = hi_q;
  assign bus.dbg_lo    = lo_q;
  assign bus.dbg_data  = (ZERO_R0 && bus.dbg_addr == '0) ? '0 : regs_q[bus.dbg_addr];
endmodule

// File: tb/tb_bus_datapath_engine.sv
// Self-checking bench for bus_datapath_engine: directed scenarios plus random
// commands compared against an arithmetic reference model of the register state.
`timescale 1ns/1ps
module tb_bus_datapath_engine;
  localparam int DATA_W = 32;
  localparam int NREGS  = 16;
  localparam int IMM_W  = 19;

  logic clock = 1'b0;
  logic reset;
  int   nChecks = 0;
  int   nFails  = 0;

  logic [31:0] mRegs [16];
  logic [31:0] mHi, mLo, mOut;
  bit          modelValid = 1'b0;

  always #5 clock = ~clock;

  bus_datapath_engine_if #(.DATA_W(DATA_W), .NREGS(NREGS), .IMM_W(IMM_W)) bus ();

  bus_datapath_engine #(.DATA_W(DATA_W), .NREGS(NREGS), .IMM_W(IMM_W), .ZERO_R0(1'b1)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mRegs[i] = '0;
    mHi = '0; mLo = '0; mOut = '0;
  endtask

  task automatic checkAllRegs();
    for (int i = 0; i < 16; i++) begin
      bus.dbg_addr = 4'(i);
      #1;
      checkOutput($sformatf("R%0d sweep", i), bus.dbg_data, mRegs[i]);
    end
    @(negedge clock);
  endtask

  task automatic checkRegLit(input logic [3:0] idx, input logic [31:0] val);
    bus.dbg_addr = idx;
    #1;
    checkOutput($sformatf("R%0d literal", idx), bus.dbg_data, val);
  endtask

  // Issue one command at a negedge, track latency and pulses, then update the model.
  task automatic applyStimulus(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                               input logic [3:0] rc, input logic [18:0] imm, input logic [31:0] inVal);
    logic [31:0] y, b, res;
    logic [63:0] wide, prod;
    longint      sy, sb, quo, rem;
    int          expLat, n, readyLow;
    bit          expErr, expDiv0, doWrite, got;
    y = (rb == 4'd0) ? 32'd0 : mRegs[rb];
    if (op >= 5'd9 && op <= 5'd11) b = {{13{imm[18]}}, imm};
    else                           b = (rc == 4'd0) ? 32'd0 : mRegs[rc];
    sy = longint'($signed(y));
    sb = longint'($signed(b));
    res = '0; expLat = 4; expErr = 1'b0; expDiv0 = 1'b0;
    case (op)
      5'd0:  res = y + b;
      5'd1:  res = y - b;
      5'd2:  res = y & b;
      5'd3:  res = y | b;
      5'd4:  res = y >> b[4:0];
      5'd5:  res = $signed(y) >>> b[4:0];
      5'd6:  res = y << b[4:0];
      5'd7:  begin wide = {y, y} >> b[4:0]; res = wide[31:0];  end
      5'd8:  begin wide = {y, y} << b[4:0]; res = wide[63:32]; end
      5'd9:  res = y + b;
      5'd10: res = y & b;
      5'd11: res = y | b;
      5'd12: expLat = 36;
      5'd13: begin expDiv0 = (b == 32'd0); expLat = expDiv0 ? 5 : 36; end
      5'd14: res = 32'd0 - y;
      5'd15: res = ~y;
      5'd16: res = mHi;
      5'd17: res = mLo;
      5'd18: res = inVal;
      5'd19: res = y;
      default: expErr = 1'b1;
    endcase
    doWrite = (op <= 5'd11) || (op >= 5'd14 && op <= 5'd18);

    checkOutput("cmd_ready before issue", {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_op = op; bus.cmd_ra = ra; bus.cmd_rb = rb; bus.cmd_rc = rc; bus.cmd_imm = imm;
    bus.in_data = ~inVal;
    bus.dbg_addr = ra;
    bus.cmd_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.cmd_op = 5'($urandom); bus.cmd_ra = 4'($urandom); bus.cmd_rb = 4'($urandom);
    bus.cmd_rc = 4'($urandom); bus.cmd_imm = 19'($urandom);
    modelValid = 1'b0;
    got = 1'b0; n = 0; readyLow = 0;
    while (!got && n < expLat + 8) begin
      @(negedge clock);
      n++;
      if (n == 2) begin
        bus.cmd_valid = 1'b0;
        bus.in_data   = inVal;
      end
      if (bus.done) got = 1'b1;
      else if (!bus.cmd_ready) readyLow++;
    end
    checkOutput($sformatf("op%0d done latency", op), 32'(got ? n : 0), 32'(expLat));
    checkOutput($sformatf("op%0d busy cycles", op), 32'(readyLow), 32'(expLat - 1));
    checkOutput($sformatf("op%0d ready/err/div0 at done", op),
                {29'd0, bus.cmd_ready, bus.err, bus.div0}, {29'd0, 1'b1, expErr, expDiv0});

    if (op == 5'd12) begin
      prod = 64'(sy * sb);
      mHi = prod[63:32]; mLo = prod[31:0];
    end else if (op == 5'd13) begin
      if (expDiv0) begin
        mLo = 32'hFFFF_FFFF; mHi = y;
      end else begin
        quo = sy / sb; rem = sy % sb;
        mLo = 32'(quo); mHi = 32'(rem);
      end
    end else if (op == 5'd19) begin
      mOut = res;
    end else if (doWrite && ra != 4'd0) begin
      mRegs[ra] = res;
    end
    modelValid = 1'b1;
    checkOutput($sformatf("op%0d dest readback R%0d", op, ra), bus.dbg_data, mRegs[ra]);

    @(negedge clock);
    checkOutput("pulses cleared after done", {29'd0, bus.done, bus.err, bus.div0}, 32'd0);
  endtask

  // Between commands HI, LO and OutPort must always equal the model.
  always @(negedge clock) begin
    if (modelValid && !reset) begin
      checkOutput("HI tracking", bus.dbg_hi, mHi);
      checkOutput("LO tracking", bus.dbg_lo, mLo);
      checkOutput("OutPort tracking", bus.out_port, mOut);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneSeen;
    logic [4:0]  rop;
    logic [31:0] rval;
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_ra = '0; bus.cmd_rb = '0;
    bus.cmd_rc = '0; bus.cmd_imm = '0; bus.in_data = '0; bus.dbg_addr = '0;
    modelReset();
    #22 reset = 1'b0;
    @(negedge clock);
    checkOutput("reset cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    checkOutput("reset pulses", {29'd0, bus.done, bus.err, bus.div0}, 32'd0);
    checkOutput("reset HI", bus.dbg_hi, 32'd0);
    checkOutput("reset LO", bus.dbg_lo, 32'd0);
    checkOutput("reset OutPort", bus.out_port, 32'd0);
    checkAllRegs();
    modelValid = 1'b1;

    applyStimulus(5'd18, 4'd1, 4'd0, 4'd0, 19'd0, 32'd5);
    applyStimulus(5'd18, 4'd2, 4'd0, 4'd0, 19'd0, 32'd7);
    applyStimulus(5'd0,  4'd3, 4'd1, 4'd2, 19'd0, 32'd0);
    checkRegLit(4'd3, 32'd12);
    @(negedge clock);

    applyStimulus(5'd18, 4'd1, 4'd0, 4'd0, 19'd0, 32'hFFFF_FFFD);
    applyStimulus(5'd12, 4'd0, 4'd1, 4'd2, 19'd0, 32'd0);
    checkOutput("MUL HI literal", bus.dbg_hi, 32'hFFFF_FFFF);
    checkOutput("MUL LO literal", bus.dbg_lo, 32'hFFFF_FFEB);
    applyStimulus(5'd17, 4'd4, 4'd0, 4'd0, 19'd0, 32'd0);
    checkRegLit(4'd4, 32'hFFFF_FFEB);
    @(negedge clock);

    applyStimulus(5'd18, 4'd1, 4'd0, 4'd0, 19'd0, 32'hFFFF_FFF9);
    applyStimulus(5'd18, 4'd2, 4'd0, 4'd0, 19'd0, 32'd2);
    applyStimulus(5'd13, 4'd0, 4'd1, 4'd2, 19'd0, 32'd0);
    checkOutput("DIV LO literal", bus.dbg_lo, 32'hFFFF_FFFD);
    checkOutput("DIV HI literal", bus.dbg_hi, 32'hFFFF_FFFF);
    applyStimulus(5'd18, 4'd2, 4'd0, 4'd0, 19'd0, 32'd0);
    applyStimulus(5'd13, 4'd0, 4'd1, 4'd2, 19'd0, 32'd0);
    checkOutput("DIV0 LO literal", bus.dbg_lo, 32'hFFFF_FFFF);
    checkOutput("DIV0 HI literal", bus.dbg_hi, 32'hFFFF_FFF9);

    applyStimulus(5'd9, 4'd0, 4'd1, 4'd0, 19'h7FFFF, 32'd0);
    checkRegLit(4'd0, 32'd0);
    @(negedge clock);
    applyStimulus(5'd9, 4'd5, 4'd0, 4'd0, 19'h40000, 32'd0);
    checkRegLit(4'd5, 32'hFFFC_0000);
    @(negedge clock);

    applyStimulus(5'd18, 4'd1, 4'd0, 4'd0, 19'd0, 32'h8000_0001);
    applyStimulus(5'd18, 4'd2, 4'd0, 4'd0, 19'd0, 32'd33);
    applyStimulus(5'd5, 4'd6, 4'd1, 4'd2, 19'd0, 32'd0);
    applyStimulus(5'd8, 4'd7, 4'd1, 4'd2, 19'd0, 32'd0);
    applyStimulus(5'd6, 4'd8, 4'd1, 4'd2, 19'd0, 32'd0);
    checkRegLit(4'd6, 32'hC000_0000);
    checkRegLit(4'd7, 32'h0000_0003);
    checkRegLit(4'd8, 32'h0000_0002);
    @(negedge clock);

    applyStimulus(5'd19, 4'd0, 4'd3, 4'd0, 19'd0, 32'd0);
    checkOutput("OUT literal", bus.out_port, 32'd12);
    applyStimulus(5'd25, 4'd3, 4'd1, 4'd2, 19'd0, 32'd0);
    checkRegLit(4'd3, 32'd12);
    @(negedge clock);
    checkAllRegs();

    // Abandon a MUL partway through its iterations with an asynchronous reset.
    bus.cmd_op = 5'd12; bus.cmd_ra = 4'd0; bus.cmd_rb = 4'd1; bus.cmd_rc = 4'd6;
    bus.cmd_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.cmd_valid = 1'b0;
    modelValid = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock);
      #1;
      if (bus.done) doneSeen++;
    end
    #2 reset = 1'b1;
    modelReset();
    #4 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (bus.done) doneSeen++;
      if (i == 0) checkOutput("cmd_ready after reset release", {31'd0, bus.cmd_ready}, 32'd1);
    end
    checkOutput("no done around mid-MUL reset", 32'(doneSeen), 32'd0);
    checkOutput("HI after mid-MUL reset", bus.dbg_hi, 32'd0);
    checkOutput("LO after mid-MUL reset", bus.dbg_lo, 32'd0);
    checkAllRegs();
    modelValid = 1'b1;

    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 9) < 3) begin
        rop = 5'd18;
      end else if ($urandom_range(0, 9) == 0) begin
        rop = 5'($urandom_range(20, 31));
      end else begin
        rop = 5'($urandom_range(0, 19));
      end
      if ($urandom_range(0, 1) == 1) rval = $urandom;
      else                           rval = 32'($urandom_range(0, 20)) - 32'd10;
      applyStimulus(rop, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 19'($urandom), rval);
      if (t % 15 == 14) checkAllRegs();
    end
    checkAllRegs();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
